// File: rtl/scytale_pkg.sv
// ============================================================================
// scytale_pkg : constants and FSM state shared by the scytale cipher blocks
// Revision    : 1.0
// ============================================================================
`default_nettype none

package scytale_pkg;

  localparam int          C_D_WIDTH       = 8;
  localparam int          C_KEY_WIDTH     = 8;
  localparam int          C_MAX_NOF_CHARS = 50;
  // Same framing token as the decryptor
  localparam logic [7:0]  C_START_TOKEN   = 8'hFA;
  localparam logic [7:0]  C_PAD_CHAR      = 8'h00;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    ENCRYPT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/scytale_encryption_if.sv
// ============================================================================
// scytale_encryption_if : character/key input and encrypted output bundle
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface scytale_encryption_if #(
  parameter int D_WIDTH   = scytale_pkg::C_D_WIDTH,
  parameter int KEY_WIDTH = scytale_pkg::C_KEY_WIDTH
);

  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;

  modport master (
    output data_i, valid_i, key_N, key_M,
    input  busy, data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, key_N, key_M,
    output busy, data_o, valid_o
  );

endinterface

`default_nettype wire

// File: rtl/scytale_index_gen.sv
// ============================================================================
// scytale_index_gen : walks p = r + i*M column-major using only adders
// Revision          : 1.0
// ============================================================================
`default_nettype none

module scytale_index_gen
  import scytale_pkg::*;
#(
  parameter int KEY_WIDTH = C_KEY_WIDTH
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_start,
  input  wire logic                   i_step,
  input  wire logic [KEY_WIDTH-1:0]   i_n,
  input  wire logic [KEY_WIDTH-1:0]   i_m,
  output logic      [2*KEY_WIDTH-1:0] o_p,
  output logic                        o_last
);

  localparam int IW = 2 * KEY_WIDTH;

  logic [IW-1:0] r_p;
  logic [IW-1:0] r_r;
  logic [IW-1:0] r_i;
  logic [IW-1:0] w_n_last;
  logic [IW-1:0] w_m_last;
  logic          w_i_wrap;

  assign w_n_last = IW'(i_n) - IW'(1);
  assign w_m_last = IW'(i_m) - IW'(1);
  assign w_i_wrap = (r_i == w_n_last);
  assign o_p      = r_p;
  assign o_last   = w_i_wrap && (r_r == w_m_last);

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_p <= '0;
      r_r <= '0;
      r_i <= '0;
    end else if (i_step) begin
      if (w_i_wrap) begin
        // Next row starts at p = r+1 (i = 0)
        r_i <= '0;
        r_r <= r_r + IW'(1);
        r_p <= r_r + IW'(1);
      end else begin
        r_i <= r_i + IW'(1);
        r_p <= r_p + IW'(i_m);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scytale_encryption.sv
// ============================================================================
// scytale_encryption : buffers plaintext until the token, then streams it out
//                      scytale-encrypted, one character per cycle
// Revision           : 1.0
// ============================================================================
`default_nettype none

module scytale_encryption
  import scytale_pkg::*;
#(
  parameter int                   D_WIDTH                = C_D_WIDTH,
  parameter int                   KEY_WIDTH              = C_KEY_WIDTH,
  parameter int                   MAX_NOF_CHARS          = C_MAX_NOF_CHARS,
  parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = D_WIDTH'(C_START_TOKEN),
  parameter logic [D_WIDTH-1:0]   PAD_CHAR               = D_WIDTH'(C_PAD_CHAR)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  scytale_encryption_if.slave     bus
);

  localparam int ADDR_W = $clog2(MAX_NOF_CHARS);
  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
  localparam int IW     = 2 * KEY_WIDTH;

  state_t               r_state;
  logic                 r_finish;
  logic                 r_busy;
  logic                 r_valid_o;
  logic [D_WIDTH-1:0]   r_data_o;
  logic [CNT_W-1:0]     r_n;
  logic [KEY_WIDTH-1:0] r_key_n;
  logic [KEY_WIDTH-1:0] r_key_m;
  logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];

  logic                 w_open;
  logic [CNT_W-1:0]     w_n_eff;
  logic                 w_token;
  logic                 w_char;
  logic                 w_degenerate;
  logic                 w_step;
  logic [IW-1:0]        w_p;
  logic                 w_last;
  logic [D_WIDTH-1:0]   w_rd_char;

  // Input is accepted in IDLE and on the completion edge, where the buffer restarts empty
  assign w_open       = (r_state == IDLE) || r_finish;
  assign w_n_eff      = r_finish ? '0 : r_n;
  assign w_token      = w_open && bus.valid_i && (bus.data_i == START_ENCRYPTION_TOKEN);
  assign w_char       = w_open && bus.valid_i && (bus.data_i != START_ENCRYPTION_TOKEN);
  assign w_degenerate = (bus.key_N == '0) || (bus.key_M == '0) || (w_n_eff == '0);
  assign w_step       = (r_state == ENCRYPT) && !r_finish;
  assign w_rd_char    = (w_p < IW'(r_n)) ? r_buf[w_p[ADDR_W-1:0]] : PAD_CHAR;

  scytale_index_gen #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_index_gen (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_token),
    .i_step  (w_step),
    .i_n     (r_key_n),
    .i_m     (r_key_m),
    .o_p     (w_p),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_n       <= '0;
      r_key_n   <= '0;
      r_key_m   <= '0;
      for (int j = 0; j < MAX_NOF_CHARS; j++) begin
        r_buf[j] <= '0;
      end
    end else begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;

      case (r_state)
        ENCRYPT: begin
          if (r_finish) begin
            r_state  <= IDLE;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
            r_n      <= '0;
            for (int j = 0; j < MAX_NOF_CHARS; j++) begin
              r_buf[j] <= '0;
            end
          end else begin
            r_valid_o <= 1'b1;
            r_data_o  <= w_rd_char;
            r_finish  <= w_last;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_token) begin
        r_key_n  <= bus.key_N;
        r_key_m  <= bus.key_M;
        r_busy   <= 1'b1;
        r_state  <= ENCRYPT;
        r_finish <= w_degenerate;
      end else if (w_char && (w_n_eff < CNT_W'(MAX_NOF_CHARS))) begin
        r_buf[w_n_eff[ADDR_W-1:0]] <= bus.data_i;
        r_n                        <= w_n_eff + CNT_W'(1);
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.valid_o = r_valid_o;
  assign bus.data_o  = r_data_o;

endmodule

`default_nettype wire

// File: tb/tb_scytale_encryption.sv
// ============================================================================
// tb_scytale_encryption : scoreboard bench for scytale_encryption
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_scytale_encryption;

  localparam int         MAX   = 50;
  localparam logic [7:0] TOKEN = 8'hFA;
  localparam logic [7:0] PAD   = 8'h00;

  logic clk;
  logic rst;

  scytale_encryption_if bus ();

  scytale_encryption dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks;
  int         n_pass;
  int         seen_cnt;
  logic [7:0] msg_q [$];
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every valid output beat is compared against the head of the scoreboard
  always @(negedge clk) begin
    logic [7:0] exp_c;
    if (bus.valid_o === 1'b1) begin
      seen_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL stream_extra: got %h, expected no beat", bus.data_o);
      end else begin
        exp_c = exp_q.pop_front();
        if (bus.data_o !== exp_c)
          $display("FAIL stream_data: got %h, expected %h", bus.data_o, exp_c);
        else
          n_pass++;
      end
    end
  end

  task automatic load_char(input logic [7:0] c);
    @(negedge clk);
    bus.data_i  = c;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    msg_q.push_back(c);
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      load_char(s[i]);
      if (i % 3 == 2) @(posedge clk);
    end
  endtask

  task automatic push_expected(input int kn, input int km, output int exp_len);
    int cnt;
    int p;
    cnt     = (msg_q.size() > MAX) ? MAX : msg_q.size();
    exp_len = (kn == 0 || km == 0 || cnt == 0) ? 0 : kn * km;
    if (exp_len > 0) begin
      for (int r = 0; r < km; r++) begin
        for (int i = 0; i < kn; i++) begin
          p = r + i * km;
          exp_q.push_back((p < cnt) ? msg_q[p] : PAD);
        end
      end
    end
    msg_q.delete();
  endtask

  task automatic drive_token(input int kn, input int km);
    @(negedge clk);
    bus.data_i  = TOKEN;
    bus.valid_i = 1'b1;
    bus.key_N   = 8'(kn);
    bus.key_M   = 8'(km);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL busy_pre_token: got %b, expected 0", bus.busy);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.key_N   = 8'($urandom);
    bus.key_M   = 8'($urandom);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.valid_o !== 1'b0)
      $display("FAIL busy_rise: got busy=%b valid=%b, expected busy=1 valid=0", bus.busy, bus.valid_o);
    else n_pass++;
  endtask

  task automatic run_token(input int kn, input int km, input bit noise);
    int  exp_len;
    int  busy_cycles;
    int  gaps;
    int  beats0;
    bit  done;
    push_expected(kn, km, exp_len);
    beats0 = seen_cnt;
    drive_token(kn, km);
    busy_cycles = 1;
    gaps        = 0;
    done        = 1'b0;
    for (int j = 1; j <= exp_len + 20 && !done; j++) begin
      if (noise && j <= exp_len) begin
        bus.valid_i = 1'($urandom_range(0, 1));
        bus.data_i  = ($urandom_range(0, 3) == 0) ? TOKEN : 8'($urandom);
      end else begin
        bus.valid_i = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) begin
        busy_cycles++;
        if (bus.valid_o !== 1'b1) gaps++;
      end else begin
        done = 1'b1;
      end
    end
    bus.valid_i = 1'b0;
    n_checks++;
    if (!done || busy_cycles != exp_len + 1)
      $display("FAIL busy_len: got %0d cycles (fell=%b), expected %0d", busy_cycles, done, exp_len + 1);
    else n_pass++;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== 8'h00)
      $display("FAIL end_outputs: got valid=%b data=%h, expected 0/00", bus.valid_o, bus.data_o);
    else n_pass++;
    n_checks++;
    if (seen_cnt - beats0 != exp_len || gaps != 0)
      $display("FAIL beat_count: got %0d beats %0d gaps, expected %0d beats 0 gaps",
               seen_cnt - beats0, gaps, exp_len);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.key_N   = '0;
    bus.key_M   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 8'h00)
      $display("FAIL reset_state: got busy=%b valid=%b data=%h, expected 0/0/00",
               bus.busy, bus.valid_o, bus.data_o);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    load_str("ABCDEF");
    run_token(2, 3, 1'b0);
  endtask

  task automatic test_pad();
    load_str("ABCD");
    run_token(3, 2, 1'b0);
  endtask

  task automatic test_hello();
    load_str("HELLOWORLD");
    run_token(5, 2, 1'b0);
  endtask

  task automatic test_degenerate();
    run_token(3, 3, 1'b0);
    load_str("QRS");
    run_token(0, 4, 1'b0);
    load_str("TUV");
    run_token(2, 0, 1'b0);
  endtask

  task automatic test_rst_abort();
    int exp_len;
    load_str("ABCDEF");
    push_expected(2, 3, exp_len);
    drive_token(2, 3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 8'h00)
      $display("FAIL rst_abort: got busy=%b valid=%b data=%h, expected 0/0/00",
               bus.busy, bus.valid_o, bus.data_o);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != exp_len - 3)
      $display("FAIL rst_abort_beats: got %0d left, expected %0d", exp_q.size(), exp_len - 3);
    else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid_o !== 1'b0) $display("FAIL rst_abort_quiet: got valid=%b, expected 0", bus.valid_o);
    else n_pass++;
    load_str("XY");
    run_token(1, 2, 1'b0);
  endtask

  task automatic test_overflow_busy();
    for (int i = 0; i < 55; i++) load_char(8'(8'h20 + i));
    run_token(10, 5, 1'b1);
    run_token(1, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_str("SCYTALE");
    run_token(3, 3, 1'b0);
    load_str("Z");
    run_token(1, 1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    seen_cnt = 0;
    test_reset();
    test_basic();
    test_pad();
    test_hello();
    test_degenerate();
    test_rst_abort();
    test_overflow_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
